fp_1d5_mult_norm_pipe: RTL and testbench

FP_1D5_MULT_NORM_PIPE -- requirements
Module: fp_1d5_mult_norm_pipe

---
 rtl/fp_1d5_mult_norm_pipe_pkg.sv | 21 ++
 rtl/fp_1d5_mult_norm_pipe_lod.sv | 18 +
 rtl/fp_1d5_mult_norm_pipe.sv | 95 +++++++++
 tb/tb_fp_1d5_mult_norm_pipe.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fp_1d5_mult_norm_pipe_pkg.sv
// Shared constants and stage bundle for the inverse-sqrt datapath.
// Holds Newton-step scaling constants and the multiply-stage register layout.
package fp_1d5_mult_norm_pipe_pkg;

    localparam int EXP_SHIFT   = 23;
    localparam int ROUND_SHIFT = 3;
    localparam int MSUB_W      = EXP_SHIFT + ROUND_SHIFT + 1;
    localparam int PROD_W      = 2 * EXP_SHIFT + ROUND_SHIFT + 2;

    localparam logic [MSUB_W-1:0] ONE_P5  = 27'h6000000;
    localparam logic [30:0]       SAT_VAL = 31'h7F7FFFFF;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic              bad;
        logic [7:0]        exp;
        logic [PROD_W-1:0] prod;
    } mul_s1_t;

endpackage

// File: rtl/fp_1d5_mult_norm_pipe_lod.sv
// 51-bit leading-one detector used to normalise the Q2.49 product.
// Purely combinational; pos is don't-care when zero is set.
module fp_lod51 (
    input  logic [50:0] din,
    output logic [5:0]  pos,
    output logic        zero
);

    always_comb begin
        pos = '0;
        for (int i = 0; i < 51; i++) begin
            if (din[i]) pos = 6'(i);
        end
    end

    assign zero = ~|din;

endmodule

// File: rtl/fp_1d5_mult_norm_pipe.sv
// Two-stage y * M_sub multiply with normalise and round-half-away.
// Stage 1 registers the raw product, stage 2 normalises and saturates.
module fp_1d5_mult_norm_pipe #(
    parameter int EXP_SHIFT   = 23,
    parameter int ROUND_SHIFT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid,
    input  logic [EXP_SHIFT+ROUND_SHIFT:0] M_sub,
    input  logic [EXP_SHIFT+7:0]          float_in_delay,
    input  logic                          error_in,
    output logic [EXP_SHIFT+7:0]          float_out,
    output logic                          ready,
    output logic                          error_out
);

    import fp_1d5_mult_norm_pipe_pkg::*;

    localparam int BOFF = 2 * EXP_SHIFT + ROUND_SHIFT;

    mul_s1_t s1;

    logic [7:0]           in_exp;
    logic [EXP_SHIFT-1:0] in_frac;
    logic                 in_bad;

    assign in_exp  = float_in_delay[EXP_SHIFT+7:EXP_SHIFT];
    assign in_frac = float_in_delay[EXP_SHIFT-1:0];
    assign in_bad  = (M_sub > ONE_P5) || (M_sub == '0) || (in_exp == '0);

    logic [5:0]           lpos;
    logic                 lzero;
    logic [PROD_W-1:0]    norm;
    logic [EXP_SHIFT-1:0] frac;
    logic                 rnd;
    logic [EXP_SHIFT:0]   frac_r;
    logic [10:0]          e_w;
    logic [EXP_SHIFT+7:0] res;
    logic                 loc_err;

    fp_lod51 u_lod (
        .din  (s1.prod),
        .pos  (lpos),
        .zero (lzero)
    );

    // Shift the leading one up to the top bit so the kept field is fixed.
    always_comb begin
        norm   = s1.prod << (6'(PROD_W - 1) - lpos);
        frac   = norm[PROD_W-2 -: EXP_SHIFT];
        rnd    = norm[PROD_W-2-EXP_SHIFT];
        frac_r = {1'b0, frac} + {{EXP_SHIFT{1'b0}}, rnd};
        e_w    = 11'(s1.exp) + 11'(lpos) + 11'(frac_r[EXP_SHIFT])
               - 11'(BOFF);
    end

    always_comb begin
        res     = '0;
        loc_err = 1'b1;
        if (s1.bad || lzero) begin
            res = '0;
        end else if ($signed(e_w) < 11'sd1) begin
            res = '0;
        end else if ($signed(e_w) > 11'sd254) begin
            res = SAT_VAL;
        end else begin
            res     = {e_w[7:0], frac_r[EXP_SHIFT-1:0]};
            loc_err = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= '0;
            float_out <= '0;
            ready     <= 1'b0;
            error_out <= 1'b0;
        end else begin
            s1.valid <= valid;
            s1.err   <= valid & error_in;
            s1.bad   <= valid & in_bad;
            s1.exp   <= in_exp;
            s1.prod  <= PROD_W'({1'b1, in_frac}) * PROD_W'(M_sub);
            ready    <= s1.valid;
            if (s1.valid) begin
                float_out <= res;
                error_out <= s1.err | loc_err;
            end else begin
                error_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_1d5_mult_norm_pipe.sv
// Directed bench for the y * M_sub normalise pipeline.
// Expected values are hand-computed float32 bit patterns.
module tb_fp_1d5_mult_norm_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [26:0] M_sub = '0;
    logic [30:0] float_in_delay = '0;
    logic        error_in = 1'b0;
    logic [30:0] float_out;
    logic        ready;
    logic        error_out;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    fp_1d5_mult_norm_pipe dut (
        .clk            (clk),
        .rst            (rst),
        .valid          (valid),
        .M_sub          (M_sub),
        .float_in_delay (float_in_delay),
        .error_in       (error_in),
        .float_out      (float_out),
        .ready          (ready),
        .error_out      (error_out)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input string tag, input logic [30:0] f,
                        input logic [26:0] m, input logic ei,
                        input logic [30:0] ef, input logic ee);
        @(negedge clk);
        float_in_delay = f;
        M_sub          = m;
        error_in       = ei;
        valid          = 1'b1;
        @(negedge clk);
        valid    = 1'b0;
        error_in = 1'b0;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(ready), 32'd1);
        chk({tag, "_f"}, 32'(float_out), 32'(ef));
        chk({tag, "_e"}, 32'(error_out), 32'(ee));
        @(negedge clk);
        chk({tag, "_idle_rdy"}, 32'(ready), 32'd0);
        chk({tag, "_idle_e"}, 32'(error_out), 32'd0);
        chk({tag, "_hold"}, 32'(float_out), 32'(ef));
    endtask

    logic [30:0] pf [5];
    logic [26:0] pm [5];
    logic [30:0] pe [5];

    initial begin
        pf[0] = 31'h3F800000; pm[0] = 27'h4000000; pe[0] = 31'h3F800000;
        pf[1] = 31'h3FC00000; pm[1] = 27'h6000000; pe[1] = 31'h40100000;
        pf[2] = 31'h3F800000; pm[2] = 27'h2000000; pe[2] = 31'h3F000000;
        pf[3] = 31'h40000000; pm[3] = 27'h4000000; pe[3] = 31'h40000000;
        pf[4] = 31'h3F800001; pm[4] = 27'h4000004; pe[4] = 31'h3F800002;

        #12;
        chk("rst_rdy", 32'(ready), 32'd0);
        chk("rst_f", 32'(float_out), 32'd0);
        chk("rst_e", 32'(error_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        send("one",    31'h3F800000, 27'h4000000, 1'b0, 31'h3F800000, 1'b0);
        send("x1p5",   31'h3FC00000, 27'h6000000, 1'b0, 31'h40100000, 1'b0);
        send("half",   31'h3F800000, 27'h2000000, 1'b0, 31'h3F000000, 1'b0);
        send("wrap",   31'h3F800000, 27'h7000000, 1'b0, 31'h00000000, 1'b1);
        send("err_in", 31'h3F800000, 27'h4000000, 1'b1, 31'h3F800000, 1'b1);
        send("ovf",    31'h7F7FFFFF, 27'h6000000, 1'b0, 31'h7F7FFFFF, 1'b1);
        send("unf",    31'h00800000, 27'h2000000, 1'b0, 31'h00000000, 1'b1);
        send("mzero",  31'h3F800000, 27'h0000000, 1'b0, 31'h00000000, 1'b1);
        send("ezero",  31'h007FFFFF, 27'h4000000, 1'b0, 31'h00000000, 1'b1);
        send("rnd_up", 31'h3F800001, 27'h4000004, 1'b0, 31'h3F800002, 1'b0);
        send("tie",    31'h3F800000, 27'h4000004, 1'b0, 31'h3F800001, 1'b0);
        send("carry",  31'h3FFFFFFF, 27'h4000004, 1'b0, 31'h40000000, 1'b0);
        send("tiny_m", 31'h3F800000, 27'h0000001, 1'b0, 31'h32800000, 1'b0);
        send("emin",   31'h00800000, 27'h4000000, 1'b0, 31'h00800000, 1'b0);
        send("emax",   31'h7F000000, 27'h6000000, 1'b0, 31'h7F400000, 1'b0);
        send("top_ok", 31'h6F000000, 27'h6000000, 1'b0, 31'h6F400000, 1'b0);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk($sformatf("bk%0d_rdy", i - 2), 32'(ready), 32'd1);
                chk($sformatf("bk%0d_f", i - 2), 32'(float_out),
                    32'(pe[i-2]));
                chk($sformatf("bk%0d_e", i - 2), 32'(error_out), 32'd0);
            end
            if (i < 5) begin
                float_in_delay = pf[i];
                M_sub          = pm[i];
                valid          = 1'b1;
            end else begin
                valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("bk_end_rdy", 32'(ready), 32'd0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) begin
                chk("pre_rst_rdy", 32'(ready), 32'd1);
                chk("pre_rst_f", 32'(float_out), 32'(pe[0]));
            end
            if (i < 3) begin
                float_in_delay = pf[i];
                M_sub          = pm[i];
                valid          = 1'b1;
            end else begin
                valid = 1'b0;
                rst   = 1'b1;
            end
        end
        #1;
        chk("arst_rdy", 32'(ready), 32'd0);
        chk("arst_f", 32'(float_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("flush%0d_rdy", i), 32'(ready), 32'd0);
        end

        send("post_rst", 31'h3FC00000, 27'h6000000, 1'b0,
             31'h40100000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
